fb_pixel_reader: RTL and testbench
==================================

Name: fb_pixel_reader

Overview:
- Parametrised frame-buffer read pipeline between video_sig_gen and the TMDS encoders.
- Replaces the fixed scale, rotate, valid-delay and blanking chain with one block.
- Converts display hcount/vcount to a frame-buffer read address, with a selectable scale factor and rotation.
- Aligns the valid and draw signals to a configurable RAM latency, expands 565 pixels to 8-bit RGB, and can binarise luma against a threshold for QR decoding.
- Mode inputs take effect only at frame boundaries, so a frame never tears.

Parameters:
- IMG_W, 320, source image width in pixels
- IMG_H, 240, source image height in pixels
- ADDR_W, 17, frame-buffer address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- RAM_LAT, 2, frame-buffer read latency in cycles, from address to data; legal range 1..4
- HC_W, 11, hcount width
- VC_W, 10, vcount width

Ports:
- clk_in  in  1  pixel clock
- rst_n_in  in  1  asynchronous, active-low reset
- hcount_in  in  HC_W  display horizontal count
- vcount_in  in  VC_W  display vertical count
- active_draw_in  in  1  display active region
- new_frame_in  in  1  single-cycle start-of-frame pulse
- scale_in  in  2  scale select: 0=1x, 1=2x, 2=4x, 3=4x
- rot_in  in  2  rotation select: 0=0°, 1=90°, 2=180°, 3=270°
- mono_in  in  1  1 = binarised output
- thresh_in  in  8  luma threshold
- fb_addr_out  out  ADDR_W  frame-buffer read address
- fb_en_out  out  1  frame-buffer read enable
- fb_data_in  in  16  frame-buffer RGB565 read data, RAM_LAT cycles after the address
- red_out, green_out, blue_out  out  8 each  pixel to the TMDS encoders
- draw_out  out  1  active_draw_in delayed to match the pixel outputs

Behaviour:
- Reset: clock and reset are fixed as one clock, clk_in, and an asynchronous active-low reset, rst_n_in. While rst_n_in=0, every output is 0, all delay lines are cleared and the mode registers hold scale=0, rot=0, mono=0, thresh=128.
- Mode capture: scale_in, rot_in, mono_in and thresh_in are copied into the mode registers only in a cycle where new_frame_in=1. The mode registers take effect from the next cycle.
- Stage 1 (registered), scaled coordinates: h'=hcount_in>>s and v'=vcount_in>>s, where s=0, 1 or 2.
- Stage 1, window check:
  - rot 0 or 2: in window when h'<IMG_W and v'<IMG_H.
  - rot 1 or 3: in window when h'<IMG_H and v'<IMG_W.
- Stage 1, source coordinates:
  - rot 0: sx=h', sy=v'
  - rot 1: sx=v', sy=IMG_H-1-h'
  - rot 2: sx=IMG_W-1-h', sy=IMG_H-1-v'
  - rot 3: sx=IMG_W-1-v', sy=h'
- Stage 1, outputs:
  - fb_addr_out = sy*IMG_W+sx, truncated to ADDR_W bits.
  - fb_en_out = the in-window flag.
  - When out of window, fb_addr_out holds its previous value.
- Valid alignment: the in-window flag passes through RAM_LAT registers and meets fb_data_in.
- Output stage (registered):
  - r8={R5,3'b0}, g8={G6,2'b0}, b8={B5,3'b0}.
  - mono=0: outputs are r8, g8, b8.
  - mono=1: luma=(2*r8+5*g8+b8)>>3, computed in 11 bits. All three channels are 255 when luma>=thresh, otherwise 0.
  - When the aligned valid flag is 0, the outputs are 0, 0, 0.
- Latency: hcount/vcount to fb_addr_out is 1 cycle. hcount/vcount to RGB is RAM_LAT+2 cycles. draw_out is active_draw_in delayed by exactly RAM_LAT+2 cycles.
- The mode registers are sampled in stage 1 and carried alongside the pixel. A mode change therefore never splits a pixel between two modes.
- Simultaneous new_frame_in and a mode change in the same cycle: the new mode applies from the next pixel.
- Reset asserted mid-frame clears the pipeline immediately. Outputs stay black until valid pixels propagate after release.

Optional Feature:
- Macro: FB_PIXEL_READER_DARK_COUNT_EN.
- When defined:
  - Adds output port dark_count_out, width ADDR_W+1.
  - A counter increments on each valid output pixel that resolves to 0 in mono mode.
  - On new_frame_in, the count is latched to dark_count_out and the counter restarts at 0, or at 1 if that cycle's pixel is itself dark.
  - The counter saturates at its maximum value. Reset clears it to 0.
- When undefined: the port and all related logic are absent, with identical behaviour otherwise.

Test Plan:
- Defaults after reset, hcount=5, vcount=2 -> fb_addr_out=645 one cycle later and fb_en_out=1. With fb_data_in=16'hF800 -> RGB=(248,0,0) at RAM_LAT+2 cycles.
- scale=1 captured on new_frame_in, hcount=10, vcount=4 -> fb_addr_out=645. With hcount=640, vcount=0 -> fb_en_out=0 and RGB=(0,0,0).
- rot=2, hcount=0, vcount=0 -> fb_addr_out=76799. rot=1, hcount=0, vcount=0 -> fb_addr_out=76480.
- mono=1, thresh=128, fb_data_in=16'hFFFF -> luma=250, RGB=(255,255,255). fb_data_in=16'h0000 -> RGB=(0,0,0). thresh=251 with 16'hFFFF -> RGB=(0,0,0).
- rot_in changed mid-frame without new_frame_in -> fb_addr_out unchanged until the pulse. rst_n_in dropped mid-line -> all outputs 0 in the same cycle. draw_out lags active_draw_in by exactly 4 cycles at RAM_LAT=2 and 5 cycles at RAM_LAT=3.
- With the macro defined, a frame of 100 valid dark pixels in mono mode -> dark_count_out=100 after the next new_frame_in.

Source files
------------

// File: rtl/fb_pixel_reader.sv
// Frame-buffer read pipeline: display counts -> scaled/rotated read address -> aligned RGB888.
// Optional dark-pixel counter for mono mode, enabled by FB_PIXEL_READER_DARK_COUNT_EN.
module fb_pixel_reader #(
    parameter int unsigned IMG_W   = 320,
    parameter int unsigned IMG_H   = 240,
    parameter int unsigned ADDR_W  = 17,
    parameter int unsigned RAM_LAT = 2,
    parameter int unsigned HC_W    = 11,
    parameter int unsigned VC_W    = 10
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [HC_W-1:0]   hcount_in,
    input  logic [VC_W-1:0]   vcount_in,
    input  logic              active_draw_in,
    input  logic              new_frame_in,
    input  logic [1:0]        scale_in,
    input  logic [1:0]        rot_in,
    input  logic              mono_in,
    input  logic [7:0]        thresh_in,
    output logic [ADDR_W-1:0] fb_addr_out,
    output logic              fb_en_out,
    input  logic [15:0]       fb_data_in,
    output logic [7:0]        red_out,
    output logic [7:0]        green_out,
    output logic [7:0]        blue_out,
`ifdef FB_PIXEL_READER_DARK_COUNT_EN
    output logic [ADDR_W:0]   dark_count_out,
`endif
    output logic              draw_out
);

    logic [1:0] scale_q;
    logic [1:0] rot_q;
    logic       mono_q;
    logic [7:0] thresh_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            scale_q  <= 2'd0;
            rot_q    <= 2'd0;
            mono_q   <= 1'b0;
            thresh_q <= 8'd128;
        end else if (new_frame_in) begin
            scale_q  <= scale_in;
            rot_q    <= rot_in;
            mono_q   <= mono_in;
            thresh_q <= thresh_in;
        end
    end

    logic [1:0]        shamt;
    logic [31:0]       h_s;
    logic [31:0]       v_s;
    logic [31:0]       sx;
    logic [31:0]       sy;
    logic              in_win;
    logic [ADDR_W-1:0] addr_d;

    always_comb begin
        shamt = (scale_q == 2'd0) ? 2'd0 : (scale_q == 2'd1) ? 2'd1 : 2'd2;
        h_s   = 32'(hcount_in) >> shamt;
        v_s   = 32'(vcount_in) >> shamt;
        unique case (rot_q)
            2'd0: begin
                sx = h_s;
                sy = v_s;
            end
            2'd1: begin
                sx = v_s;
                sy = IMG_H - 1 - h_s;
            end
            2'd2: begin
                sx = IMG_W - 1 - h_s;
                sy = IMG_H - 1 - v_s;
            end
            default: begin
                sx = IMG_W - 1 - v_s;
                sy = h_s;
            end
        endcase
        // Quarter-turn rotations swap which display axis spans the source width.
        in_win = rot_q[0] ? ((h_s < IMG_H) && (v_s < IMG_W))
                          : ((h_s < IMG_W) && (v_s < IMG_H));
        addr_d = ADDR_W'(sy * IMG_W + sx);
    end

    // Per-pixel tag {valid, mono, thresh} travels with the pixel so mode never splits mid-pixel.
    logic [ADDR_W-1:0]         addr_q;
    logic [9:0]                tag_s1_q;
    logic [RAM_LAT-1:0][9:0]   tag_pipe_q;
    logic [RAM_LAT+1:0]        draw_pipe_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            addr_q      <= '0;
            tag_s1_q    <= '0;
            tag_pipe_q  <= '0;
            draw_pipe_q <= '0;
        end else begin
            if (in_win) begin
                addr_q <= addr_d;
            end
            tag_s1_q      <= {in_win, mono_q, thresh_q};
            tag_pipe_q[0] <= tag_s1_q;
            for (int i = 1; i < RAM_LAT; i++) begin
                tag_pipe_q[i] <= tag_pipe_q[i-1];
            end
            draw_pipe_q <= {draw_pipe_q[RAM_LAT:0], active_draw_in};
        end
    end

    assign fb_addr_out = addr_q;
    assign fb_en_out   = tag_s1_q[9];
    assign draw_out    = draw_pipe_q[RAM_LAT+1];

    logic        vld_al;
    logic        mono_al;
    logic [7:0]  thr_al;
    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;
    logic [10:0] luma_w;
    logic        lit;
    logic [23:0] rgb_d;
    logic [23:0] rgb_q;

    always_comb begin
        vld_al  = tag_pipe_q[RAM_LAT-1][9];
        mono_al = tag_pipe_q[RAM_LAT-1][8];
        thr_al  = tag_pipe_q[RAM_LAT-1][7:0];
        r8      = {fb_data_in[15:11], 3'b000};
        g8      = {fb_data_in[10:5], 2'b00};
        b8      = {fb_data_in[4:0], 3'b000};
        luma_w  = {2'b00, r8, 1'b0} + ({3'b000, g8} * 11'd5) + {3'b000, b8};
        // (luma_w >> 3) >= thr is the same test as luma_w >= thr * 8.
        lit     = (luma_w >= {thr_al, 3'b000});
        rgb_d   = 24'h000000;
        if (vld_al) begin
            if (mono_al) begin
                rgb_d = lit ? 24'hFFFFFF : 24'h000000;
            end else begin
                rgb_d = {r8, g8, b8};
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign red_out   = rgb_q[23:16];
    assign green_out = rgb_q[15:8];
    assign blue_out  = rgb_q[7:0];

`ifdef FB_PIXEL_READER_DARK_COUNT_EN
    logic            dark_pix;
    logic [ADDR_W:0] dark_cnt_q;
    logic [ADDR_W:0] dark_count_q;

    assign dark_pix = vld_al & mono_al & ~lit;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            dark_cnt_q   <= '0;
            dark_count_q <= '0;
        end else if (new_frame_in) begin
            dark_count_q <= dark_cnt_q;
            dark_cnt_q   <= {{ADDR_W{1'b0}}, dark_pix};
        end else if (dark_pix && (dark_cnt_q != '1)) begin
            dark_cnt_q <= dark_cnt_q + 1'b1;
        end
    end

    assign dark_count_out = dark_count_q;
`endif

endmodule

// File: tb/tb_fb_pixel_reader.sv
// Self-checking bench for fb_pixel_reader: directed steps then randomized stimulus
// against an arithmetic reference model; a second instance checks RAM_LAT=3 alignment.
module tb_fb_pixel_reader;

    localparam int unsigned IMG_W   = 320;
    localparam int unsigned IMG_H   = 240;
    localparam int unsigned ADDR_W  = 17;
    localparam int unsigned RAM_LAT = 2;
    localparam int unsigned HC_W    = 11;
    localparam int unsigned VC_W    = 10;
    localparam int          L2      = RAM_LAT + 2;
    localparam int          L3      = 5;
    localparam int          NC      = 4096;

    logic              clk = 1'b0;
    logic              rst_n_in = 1'b1;
    logic [HC_W-1:0]   hcount_in = '0;
    logic [VC_W-1:0]   vcount_in = '0;
    logic              active_draw_in = 1'b0;
    logic              new_frame_in = 1'b0;
    logic [1:0]        scale_in = '0;
    logic [1:0]        rot_in = '0;
    logic              mono_in = 1'b0;
    logic [7:0]        thresh_in = 8'd128;
    logic [ADDR_W-1:0] fb_addr_out, a3_addr;
    logic              fb_en_out, a3_en;
    logic [15:0]       fb_data_in;
    logic [7:0]        red_out, green_out, blue_out, r3, g3, b3;
    logic              draw_out, d3;
`ifdef FB_PIXEL_READER_DARK_COUNT_EN
    logic [ADDR_W:0]   dark_count_out, dark3;
`endif

    always #5 clk = ~clk;

    fb_pixel_reader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .RAM_LAT(RAM_LAT),
                      .HC_W(HC_W), .VC_W(VC_W)) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n_in),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .active_draw_in (active_draw_in),
        .new_frame_in   (new_frame_in),
        .scale_in       (scale_in),
        .rot_in         (rot_in),
        .mono_in        (mono_in),
        .thresh_in      (thresh_in),
        .fb_addr_out    (fb_addr_out),
        .fb_en_out      (fb_en_out),
        .fb_data_in     (fb_data_in),
        .red_out        (red_out),
        .green_out      (green_out),
        .blue_out       (blue_out),
`ifdef FB_PIXEL_READER_DARK_COUNT_EN
        .dark_count_out (dark_count_out),
`endif
        .draw_out       (draw_out)
    );

    fb_pixel_reader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .RAM_LAT(3),
                      .HC_W(HC_W), .VC_W(VC_W)) dut3 (
        .clk_in         (clk),
        .rst_n_in       (rst_n_in),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .active_draw_in (active_draw_in),
        .new_frame_in   (new_frame_in),
        .scale_in       (scale_in),
        .rot_in         (rot_in),
        .mono_in        (mono_in),
        .thresh_in      (thresh_in),
        .fb_addr_out    (a3_addr),
        .fb_en_out      (a3_en),
        .fb_data_in     (16'h0000),
        .red_out        (r3),
        .green_out      (g3),
        .blue_out       (b3),
`ifdef FB_PIXEL_READER_DARK_COUNT_EN
        .dark_count_out (dark3),
`endif
        .draw_out       (d3)
    );

    // Behavioural frame-buffer RAM with RAM_LAT cycles from address to data.
    logic [15:0] mem [0:(1<<ADDR_W)-1];
    logic [15:0] rd_pipe [RAM_LAT];
    always @(posedge clk) begin
        rd_pipe[0] <= mem[fb_addr_out];
        for (int i = 1; i < RAM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign fb_data_in = rd_pipe[RAM_LAT-1];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int e_addr [NC];
    bit e_en [NC];
    logic [23:0] e_rgb [NC];
    logic [23:0] e_rgb3 [NC];
    bit e_draw [NC];
    bit e_draw3 [NC];
    int m_scale, m_rot, m_thr, last_addr;
    bit m_mono;

    function automatic logic [23:0] pix_of(input logic [15:0] d, input bit mono, input int thr);
        int r, g, b, luma;
        r = int'(d[15:11]) * 8;
        g = int'(d[10:5]) * 4;
        b = int'(d[4:0]) * 8;
        if (!mono) return {8'(r), 8'(g), 8'(b)};
        luma = (2 * r + 5 * g + b) / 8;
        return (luma >= thr) ? 24'hFFFFFF : 24'h000000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_all();
        chk("addr", fb_addr_out, e_addr[cyc]);
        chk("en", fb_en_out, e_en[cyc]);
        chk("rgb", {red_out, green_out, blue_out}, e_rgb[cyc]);
        chk("draw", draw_out, e_draw[cyc]);
        chk("addr_lat3", a3_addr, e_addr[cyc]);
        chk("en_lat3", a3_en, e_en[cyc]);
        chk("rgb_lat3", {r3, g3, b3}, e_rgb3[cyc]);
        chk("draw_lat3", d3, e_draw3[cyc]);
    endtask

    task automatic tick(input int h, input int v, input bit draw, input bit nf);
        int s, hs, vs, sx, sy;
        bit win;
        hcount_in      = HC_W'(h);
        vcount_in      = VC_W'(v);
        active_draw_in = draw;
        new_frame_in   = nf;
        s  = (m_scale == 0) ? 0 : (m_scale == 1) ? 1 : 2;
        hs = h >> s;
        vs = v >> s;
        case (m_rot)
            0:       begin sx = hs;            sy = vs;            end
            1:       begin sx = vs;            sy = IMG_H - 1 - hs; end
            2:       begin sx = IMG_W - 1 - hs; sy = IMG_H - 1 - vs; end
            default: begin sx = IMG_W - 1 - vs; sy = hs;            end
        endcase
        if (m_rot % 2 == 1) win = (hs < IMG_H) && (vs < IMG_W);
        else                win = (hs < IMG_W) && (vs < IMG_H);
        if (win) last_addr = (sy * IMG_W + sx) % (1 << ADDR_W);
        e_addr[cyc+1]   = last_addr;
        e_en[cyc+1]     = win;
        e_rgb[cyc+L2]   = win ? pix_of(mem[last_addr], m_mono, m_thr) : 24'h0;
        e_draw[cyc+L2]  = draw;
        e_rgb3[cyc+L3]  = win ? pix_of(16'h0000, m_mono, m_thr) : 24'h0;
        e_draw3[cyc+L3] = draw;
        if (nf) begin
            m_scale = scale_in;
            m_rot   = rot_in;
            m_mono  = mono_in;
            m_thr   = thresh_in;
        end
        @(posedge clk);
        #1;
        cyc++;
        check_all();
        new_frame_in = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1000, 500, 0, 0);
    endtask

    task automatic do_reset();
        rst_n_in     = 1'b0;
        new_frame_in = 1'b0;
        #1;
        chk("rst_addr", fb_addr_out, 0);
        chk("rst_en", fb_en_out, 0);
        chk("rst_rgb", {red_out, green_out, blue_out}, 0);
        chk("rst_draw", draw_out, 0);
        for (int i = cyc + 1; i < NC; i++) begin
            e_addr[i] = 0; e_en[i] = 0; e_rgb[i] = 0; e_rgb3[i] = 0;
            e_draw[i] = 0; e_draw3[i] = 0;
        end
        m_scale = 0; m_rot = 0; m_mono = 0; m_thr = 128; last_addr = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            check_all();
        end
        rst_n_in = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 16'($urandom);
        for (int i = 0; i < NC; i++) begin
            e_addr[i] = 0; e_en[i] = 0; e_rgb[i] = 0; e_rgb3[i] = 0;
            e_draw[i] = 0; e_draw3[i] = 0;
        end
        #2;
        do_reset();

        // Defaults: 1x, no rotation, colour.
        mem[645] = 16'hF800;
        tick(5, 2, 1, 0);
        chk("dir_addr645", fb_addr_out, 645);
        chk("dir_en", fb_en_out, 1);
        idle(3);
        chk("dir_red", {red_out, green_out, blue_out}, 24'hF80000);
        chk("dir_draw_lag", draw_out, 1);

        // 2x scale captured on the pulse; later scale_in change ignored.
        scale_in = 2'd1;
        tick(1000, 500, 0, 1);
        scale_in = 2'd2;
        tick(10, 4, 1, 0);
        chk("dir_scale2_addr", fb_addr_out, 645);
        tick(640, 0, 1, 0);
        chk("dir_scale2_oow_en", fb_en_out, 0);
        chk("dir_scale2_hold", fb_addr_out, 645);
        idle(3);
        chk("dir_oow_black", {red_out, green_out, blue_out}, 24'h0);

        // Rotations.
        scale_in = 2'd0; rot_in = 2'd2;
        tick(1000, 500, 0, 1);
        tick(0, 0, 1, 0);
        chk("dir_rot180", fb_addr_out, 76799);
        rot_in = 2'd1;
        tick(1000, 500, 0, 1);
        tick(0, 0, 1, 0);
        chk("dir_rot90", fb_addr_out, 76480);

        // Mono thresholding.
        rot_in = 2'd0; mono_in = 1'b1; thresh_in = 8'd128;
        mem[10] = 16'hFFFF;
        mem[11] = 16'h0000;
        tick(1000, 500, 0, 1);
        tick(10, 0, 1, 0);
        tick(11, 0, 1, 0);
        idle(2);
        chk("dir_mono_white", {red_out, green_out, blue_out}, 24'hFFFFFF);
        idle(1);
        chk("dir_mono_black", {red_out, green_out, blue_out}, 24'h0);
        thresh_in = 8'd251;
        tick(1000, 500, 0, 1);
        tick(10, 0, 1, 0);
        idle(3);
        chk("dir_thresh251", {red_out, green_out, blue_out}, 24'h0);
        thresh_in = 8'd250;
        tick(1000, 500, 0, 1);
        tick(10, 0, 1, 0);
        idle(3);
        chk("dir_thresh250", {red_out, green_out, blue_out}, 24'hFFFFFF);

        // Rotation change without a pulse must not take effect.
        mono_in = 1'b0; thresh_in = 8'd128; rot_in = 2'd0;
        tick(1000, 500, 0, 1);
        rot_in = 2'd2;
        tick(5, 2, 1, 0);
        chk("dir_no_pulse", fb_addr_out, 645);
        tick(1000, 500, 0, 1);
        tick(5, 2, 1, 0);
        chk("dir_after_pulse", fb_addr_out, 76154);

        // Mid-line reset with live pixels in flight.
        rot_in = 2'd0;
        tick(1000, 500, 0, 1);
        for (int i = 0; i < 8; i++) begin
            mem[100 + i] = 16'hF81F;
            tick(100 + i, 0, 1, 0);
        end
        do_reset();
        for (int i = 0; i < 6; i++) tick(200 + i, 1, 1, 0);

        // Randomized: mode inputs wiggle every cycle, captured only on pulses.
        for (int i = 0; i < 1500; i++) begin
            scale_in  = 2'($urandom);
            rot_in    = 2'($urandom);
            mono_in   = 1'($urandom);
            thresh_in = 8'($urandom);
            tick($urandom_range(0, 1023), $urandom_range(0, 600), 1'($urandom),
                 ($urandom_range(0, 15) == 0));
        end

`ifdef FB_PIXEL_READER_DARK_COUNT_EN
        scale_in = 2'd0; rot_in = 2'd0; mono_in = 1'b1; thresh_in = 8'd255;
        idle(6);
        tick(1000, 500, 0, 1);
        for (int i = 0; i < 100; i++) tick(i, 3, 1, 0);
        idle(6);
        tick(1000, 500, 0, 1);
        chk("dark_count100", dark_count_out, 100);
`endif

        idle(6);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
